segment_swap_scheduler: RTL and testbench
=========================================

Name: segment_swap_scheduler

Overview:
Controls which double-buffered segment (0/1) the modulation or STM index generator reads from. Latches a segment-change request with its transition mode and fires the swap at the condition that mode selects: loop boundary, system time, GPIO edge, or autonomous ping-pong. Counts completed loops per segment and raises STOP when a finite repeat count is exhausted. One instance sits between the control register file and each of the MOD and STM index generators.

Parameters:
REP_WIDTH, 16, repeat-count width; all-ones means infinite.
SYS_TIME_WIDTH, 57, width of the system-time bus compared in SYS_TIME mode.

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous, active-low reset
UPDATE_SETTINGS  in  1  one-cycle strobe; latch a new request
REQ_RD_SEGMENT  in  1  requested segment
REP0  in  REP_WIDTH  repeat count, segment 0
REP1  in  REP_WIDTH  repeat count, segment 1
TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
TRANSITION_VALUE  in  64  mode argument
SYS_TIME  in  SYS_TIME_WIDTH  free-running system time, already synchronous to CLK
GPIO_IN  in  4  GPIO inputs, already synchronised
LOOP_END  in  1  strobe from the index generator when the index wraps from cycle-1 to 0
SEGMENT  out  1  active read segment
SWAP  out  1  one-cycle strobe, same cycle SEGMENT changes
STOP  out  1  finite repeats exhausted; generator holds its last index
PENDING  out  1  request latched, swap not yet taken
LOOP_CNT  out  REP_WIDTH  loops completed in the current segment

Behaviour:
- Reset (RST_N=0 at a CLK edge): SEGMENT=0, SWAP=0, STOP=0, PENDING=0, LOOP_CNT=0, ext_active=0, state IDLE, GPIO previous-sample register cleared.
- States and transitions:
  - IDLE: no pending request.
  - WAIT: request latched. Registers hold segment, mode and value.
  - On swap, WAIT goes back to IDLE.
- UPDATE_SETTINGS with a valid mode:
  - Latches the request and sets PENDING=1 on the next cycle.
  - Latching in WAIT replaces the older request; the last write wins.
- UPDATE_SETTINGS with any other mode value:
  - The request is dropped, and any pending request is cancelled (PENDING=0, IDLE).
- Swap conditions, evaluated in WAIT only:
  - SYNC_IDX: the first LOOP_END after the latch cycle. If STOP=1, the swap happens on the cycle after the latch.
  - SYS_TIME: SYS_TIME >= TRANSITION_VALUE[SYS_TIME_WIDTH-1:0]. A time already in the past swaps on the first WAIT cycle.
  - GPIO: rising edge on GPIO_IN[TRANSITION_VALUE[1:0]], i.e. current high and previous-cycle sample low. The previous-sample register updates every cycle. An edge coinciding with the UPDATE_SETTINGS cycle does not count.
  - EXT: the same condition as SYNC_IDX, and it additionally sets ext_active=1. Any other mode clears ext_active when its swap is taken.
- Swap action, registered with 1 cycle latency from the condition:
  - SEGMENT <= latched segment; SWAP=1 for one cycle.
  - LOOP_CNT <= 0, STOP <= 0, PENDING <= 0.
  - A swap to the already-active segment is legal: it restarts the loop count and still pulses SWAP.
- Loop counting, outside of swap cycles:
  - LOOP_END with STOP=0 increments LOOP_CNT.
  - Let REP be the active segment's repeat count. If REP is all-ones, LOOP_CNT saturates at all-ones and STOP never asserts.
  - Otherwise the segment plays REP+1 loops. The LOOP_END that makes LOOP_CNT equal REP+1 sets STOP=1 (if not ext_active).
  - LOOP_END while STOP=1 is ignored.
- ext_active=1 with no pending request: at the exhausting LOOP_END, instead of setting STOP, it toggles SEGMENT, pulses SWAP and clears LOOP_CNT. The block keeps ping-ponging indefinitely.
- Simultaneous events:
  - A pending-request swap and an EXT auto-toggle on the same cycle: the pending request wins.
  - A LOOP_END consumed by a swap does not increment the new segment's LOOP_CNT.
  - UPDATE_SETTINGS arriving on the same cycle as a swap condition for the old request: the old request swaps, then the new one is latched, and PENDING=1 the following cycle.
- Reset mid-WAIT discards the request; there is no SWAP pulse.

Optional Feature:
SEGMENT_SWAP_EXT_EN:
- Defined: EXT mode (0xF0) behaves as described above.
- Undefined: 0xF0 is an invalid mode and is dropped like any other invalid value; ext_active is tied to 0 and no auto-toggle logic is synthesised.

Test Plan:
1. Reset; REP0=1; four LOOP_END pulses -> LOOP_CNT 1, then 2 with STOP=1; the third and fourth are ignored.
2. REQ=1, mode SYNC_IDX, then LOOP_END 10 cycles later -> SWAP high one cycle after that LOOP_END, SEGMENT=1, LOOP_CNT=0, PENDING=0.
3. Mode SYS_TIME, value 1000, SYS_TIME ramping from 990 -> SWAP on the cycle after SYS_TIME=1000. Repeat with value 500 while SYS_TIME=990 -> SWAP on the first WAIT cycle.
4. Mode GPIO, value 2, GPIO_IN[2] already high at latch; pulse GPIO_IN[1] -> no swap. Drop and re-raise GPIO_IN[2] -> SWAP one cycle after the rising edge.
5. With SEGMENT_SWAP_EXT_EN: REP0=REP1=0, mode EXT -> after the first swap, SEGMENT toggles at every LOOP_END and STOP stays 0. Without the macro -> request dropped, PENDING stays 0.
6. Mode 0x07 while a SYS_TIME request is pending -> PENDING=0, no SWAP ever. Reset asserted mid-WAIT -> all outputs back to reset values.

Source files
------------

// File: rtl/segment_swap_scheduler.sv
// segment_swap_scheduler
// Selects which half of a double-buffered segment pair (0/1) the MOD/STM
// index generator reads. A segment-change request is latched together with
// its transition mode and taken when that mode's condition holds: loop
// boundary (SYNC_IDX), system time (SYS_TIME) or a GPIO rising edge (GPIO).
// Completed loops are counted per segment; a finite repeat count raises STOP
// once exhausted (an all-ones repeat count means play forever).
// Optional feature: define SEGMENT_SWAP_EXT_EN to enable EXT mode (0xF0),
// which swaps like SYNC_IDX and then ping-pongs between segments on its own
// at every exhausted repeat count instead of stopping.
module segment_swap_scheduler #(
    parameter int REP_WIDTH      = 16,
    parameter int SYS_TIME_WIDTH = 57
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      UPDATE_SETTINGS,
    input  logic                      REQ_RD_SEGMENT,
    input  logic [REP_WIDTH-1:0]      REP0,
    input  logic [REP_WIDTH-1:0]      REP1,
    input  logic [7:0]                TRANSITION_MODE,
    input  logic [63:0]               TRANSITION_VALUE,
    input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
    input  logic [3:0]                GPIO_IN,
    input  logic                      LOOP_END,
    output logic                      SEGMENT,
    output logic                      SWAP,
    output logic                      STOP,
    output logic                      PENDING,
    output logic [REP_WIDTH-1:0]      LOOP_CNT
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO     = 8'h02;
`ifdef SEGMENT_SWAP_EXT_EN
    localparam logic [7:0] MODE_EXT      = 8'hF0;
`endif

    localparam logic [REP_WIDTH-1:0] CNT_ZERO = {REP_WIDTH{1'b0}};
    localparam logic [REP_WIDTH-1:0] CNT_ONE  = {{(REP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REP_WIDTH-1:0] CNT_ALL  = {REP_WIDTH{1'b1}};

    // Modes that may be latched; anything else cancels a pending request.
    function automatic logic mode_is_valid(input logic [7:0] mode);
        logic ok;
        case (mode)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO: ok = 1'b1;
`ifdef SEGMENT_SWAP_EXT_EN
            MODE_EXT:                                ok = 1'b1;
`endif
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [0:0]                state_r;
    logic                      req_seg_r;
    logic [7:0]                req_mode_r;
    logic [SYS_TIME_WIDTH-1:0] req_value_r;
    logic [3:0]                gpio_prev_r;
    logic                      segment_r;
    logic                      swap_r;
    logic                      stop_r;
    logic [REP_WIDTH-1:0]      loop_cnt_r;

    logic [REP_WIDTH-1:0]      rep_s;
    logic [1:0]                gpio_sel_s;
    logic                      gpio_edge_s;
    logic                      time_reached_s;
    logic                      swap_cond_s;
    logic                      loop_step_s;
    logic                      rep_inf_s;
    logic                      exhaust_s;
    logic                      ext_active_s;
    logic                      auto_toggle_s;

    // Swap condition of the latched request and loop-count qualifiers.
    always_comb begin
        rep_s          = segment_r ? REP1 : REP0;
        gpio_sel_s     = req_value_r[1:0];
        gpio_edge_s    = GPIO_IN[gpio_sel_s] & ~gpio_prev_r[gpio_sel_s];
        time_reached_s = (SYS_TIME >= req_value_r);
        swap_cond_s    = 1'b0;
        if (state_r == ST_WAIT) begin
            case (req_mode_r)
                MODE_SYNC_IDX: swap_cond_s = LOOP_END | stop_r;
                MODE_SYS_TIME: swap_cond_s = time_reached_s;
                MODE_GPIO:     swap_cond_s = gpio_edge_s;
`ifdef SEGMENT_SWAP_EXT_EN
                MODE_EXT:      swap_cond_s = LOOP_END | stop_r;
`endif
                default:       swap_cond_s = 1'b0;
            endcase
        end else begin
            swap_cond_s = 1'b0;
        end
        loop_step_s = LOOP_END & ~stop_r;
        rep_inf_s   = &rep_s;
        exhaust_s   = loop_step_s & ~rep_inf_s & (loop_cnt_r == rep_s);
    end

`ifdef SEGMENT_SWAP_EXT_EN
    logic ext_active_r;

    // Remember whether the last request-driven swap was an EXT swap.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ext_active_r <= 1'b0;
        end else if (swap_cond_s) begin
            ext_active_r <= (req_mode_r == MODE_EXT);
        end
    end

    assign ext_active_s  = ext_active_r;
    // Ping-pong only when no request is waiting; a pending request has priority.
    assign auto_toggle_s = ext_active_r & (state_r == ST_IDLE) & exhaust_s;
`else
    assign ext_active_s  = 1'b0;
    assign auto_toggle_s = 1'b0;
`endif

    // Request latch: last valid write wins, invalid write cancels, swap retires.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            req_seg_r   <= 1'b0;
            req_mode_r  <= 8'h00;
            req_value_r <= {SYS_TIME_WIDTH{1'b0}};
        end else if (UPDATE_SETTINGS) begin
            if (mode_is_valid(TRANSITION_MODE)) begin
                state_r     <= ST_WAIT;
                req_seg_r   <= REQ_RD_SEGMENT;
                req_mode_r  <= TRANSITION_MODE;
                req_value_r <= TRANSITION_VALUE[SYS_TIME_WIDTH-1:0];
            end else begin
                state_r <= ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (swap_cond_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Active segment, swap strobe, loop counter and stop flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gpio_prev_r <= 4'b0000;
            segment_r   <= 1'b0;
            swap_r      <= 1'b0;
            stop_r      <= 1'b0;
            loop_cnt_r  <= CNT_ZERO;
        end else begin
            gpio_prev_r <= GPIO_IN;
            swap_r      <= 1'b0;
            if (swap_cond_s) begin
                // A LOOP_END consumed here is not counted in the new segment.
                segment_r  <= req_seg_r;
                swap_r     <= 1'b1;
                stop_r     <= 1'b0;
                loop_cnt_r <= CNT_ZERO;
            end else if (auto_toggle_s) begin
                segment_r  <= ~segment_r;
                swap_r     <= 1'b1;
                loop_cnt_r <= CNT_ZERO;
            end else if (loop_step_s) begin
                if (rep_inf_s) begin
                    if (loop_cnt_r != CNT_ALL) begin
                        loop_cnt_r <= loop_cnt_r + CNT_ONE;
                    end
                end else begin
                    loop_cnt_r <= loop_cnt_r + CNT_ONE;
                    if (exhaust_s && !ext_active_s) begin
                        stop_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign SEGMENT  = segment_r;
    assign SWAP     = swap_r;
    assign STOP     = stop_r;
    assign PENDING  = (state_r == ST_WAIT);
    assign LOOP_CNT = loop_cnt_r;

endmodule

// File: tb/tb_segment_swap_scheduler.sv
// tb_segment_swap_scheduler
// Directed scenarios plus randomized traffic, compared every cycle against a
// behavioural model of the segment scheduler. Honors SEGMENT_SWAP_EXT_EN.
module tb_segment_swap_scheduler;
    localparam int RW = 16;
    localparam int TW = 57;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          UPDATE_SETTINGS;
    logic          REQ_RD_SEGMENT;
    logic [RW-1:0] REP0;
    logic [RW-1:0] REP1;
    logic [7:0]    TRANSITION_MODE;
    logic [63:0]   TRANSITION_VALUE;
    logic [TW-1:0] SYS_TIME;
    logic [3:0]    GPIO_IN;
    logic          LOOP_END;
    logic          SEGMENT;
    logic          SWAP;
    logic          STOP;
    logic          PENDING;
    logic [RW-1:0] LOOP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_seg, m_swap, m_stop, m_pend, m_ext, p_seg;
    int          m_cnt;
    logic [7:0]  p_mode;
    logic [63:0] p_val;
    logic [3:0]  m_gprev;

    segment_swap_scheduler #(.REP_WIDTH(RW), .SYS_TIME_WIDTH(TW)) dut (
        .CLK(CLK), .RST_N(RST_N), .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REP0(REP0), .REP1(REP1),
        .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .LOOP_END(LOOP_END),
        .SEGMENT(SEGMENT), .SWAP(SWAP), .STOP(STOP), .PENDING(PENDING),
        .LOOP_CNT(LOOP_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_valid(input logic [7:0] m);
`ifdef SEGMENT_SWAP_EXT_EN
        return (m == 8'h00) || (m == 8'h01) || (m == 8'h02) || (m == 8'hF0);
`else
        return (m == 8'h00) || (m == 8'h01) || (m == 8'h02);
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit          fire;
        int          rep;
        int          nxt;
        int          sel;
        logic [63:0] tmask;
        if (!RST_N) begin
            m_seg = 0; m_swap = 0; m_stop = 0; m_pend = 0; m_ext = 0;
            m_cnt = 0; m_gprev = 4'b0000;
            return;
        end
        tmask = (64'd1 << TW) - 64'd1;
        sel   = int'(p_val[1:0]);
        fire  = 0;
        if (m_pend) begin
            if (p_mode == 8'h00 || p_mode == 8'hF0) fire = LOOP_END || m_stop;
            else if (p_mode == 8'h01) fire = ({7'd0, SYS_TIME} >= (p_val & tmask));
            else if (p_mode == 8'h02) fire = GPIO_IN[sel] && !m_gprev[sel];
        end
        rep    = m_seg ? int'(REP1) : int'(REP0);
        m_swap = 0;
        if (fire) begin
            m_seg = p_seg; m_swap = 1; m_cnt = 0; m_stop = 0;
            m_ext = (p_mode == 8'hF0);
        end else if (LOOP_END && !m_stop) begin
            nxt = m_cnt + 1;
            if (rep == 65535) begin
                m_cnt = (nxt > 65535) ? 65535 : nxt;
            end else if (nxt == rep + 1 && m_ext && !m_pend) begin
                m_seg = !m_seg; m_swap = 1; m_cnt = 0;
            end else begin
                m_cnt = nxt % 65536;
                if (nxt == rep + 1 && !m_ext) m_stop = 1;
            end
        end
        if (UPDATE_SETTINGS) begin
            if (m_valid(TRANSITION_MODE)) begin
                m_pend = 1; p_seg = REQ_RD_SEGMENT;
                p_mode = TRANSITION_MODE; p_val = TRANSITION_VALUE;
            end else begin
                m_pend = 0;
            end
        end else if (fire) begin
            m_pend = 0;
        end
        m_gprev = GPIO_IN;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update model, let the edge pass, compare every output.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check("SEGMENT",  64'(SEGMENT),  64'(m_seg));
        check("SWAP",     64'(SWAP),     64'(m_swap));
        check("STOP",     64'(STOP),     64'(m_stop));
        check("PENDING",  64'(PENDING),  64'(m_pend));
        check("LOOP_CNT", 64'(LOOP_CNT), 64'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_loop();
        LOOP_END = 1'b1;
        tick();
        LOOP_END = 1'b0;
    endtask

    task automatic do_update(input bit seg, input logic [7:0] mode, input logic [63:0] val);
        UPDATE_SETTINGS  = 1'b1;
        REQ_RD_SEGMENT   = seg;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = val;
        tick();
        UPDATE_SETTINGS  = 1'b0;
    endtask

    function automatic logic [RW-1:0] pick_rep();
        case ($urandom_range(0, 4))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return 16'd2;
            3:       return 16'd3;
            default: return 16'hFFFF;
        endcase
    endfunction

    logic [TW-1:0] cur_t;
    logic [TW-1:0] swap_at;
    logic [TW-1:0] target;
    bit            found;
    bit            seen_swap;

    initial begin
        RST_N = 1'b0; UPDATE_SETTINGS = 1'b0; REQ_RD_SEGMENT = 1'b0;
        REP0 = 16'd1; REP1 = 16'd5; TRANSITION_MODE = 8'h00;
        TRANSITION_VALUE = 64'd0; SYS_TIME = 57'd0; GPIO_IN = 4'b0000;
        LOOP_END = 1'b0;
        p_seg = 0; p_mode = 8'h00; p_val = 64'd0;

        // Reset values
        ticks(2);
        check("rst_segment", 64'(SEGMENT), 64'd0);
        check("rst_pending", 64'(PENDING), 64'd0);
        check("rst_loop_cnt", 64'(LOOP_CNT), 64'd0);
        RST_N = 1'b1;
        tick();

        // 1: REP0=1 plays two loops then stops; further LOOP_ENDs ignored
        pulse_loop(); tick();
        check("t1_cnt_after_1", 64'(LOOP_CNT), 64'd1);
        check("t1_stop_after_1", 64'(STOP), 64'd0);
        pulse_loop(); tick();
        check("t1_cnt_after_2", 64'(LOOP_CNT), 64'd2);
        check("t1_stop_after_2", 64'(STOP), 64'd1);
        pulse_loop(); tick(); pulse_loop(); tick();
        check("t1_cnt_after_4", 64'(LOOP_CNT), 64'd2);
        check("t1_stop_after_4", 64'(STOP), 64'd1);

        // SYNC_IDX while stopped swaps right after the first WAIT cycle
        do_update(1'b0, 8'h00, 64'd0);
        check("stop_sync_pending", 64'(PENDING), 64'd1);
        tick();
        check("stop_sync_swap", 64'(SWAP), 64'd1);
        check("stop_sync_stop_cleared", 64'(STOP), 64'd0);

        // 2: SYNC_IDX to segment 1, LOOP_END ten cycles later
        REP0 = 16'd5; REP1 = 16'd5;
        do_update(1'b1, 8'h00, 64'd0);
        ticks(10);
        check("t2_pending_before", 64'(PENDING), 64'd1);
        check("t2_segment_before", 64'(SEGMENT), 64'd0);
        pulse_loop();
        check("t2_swap", 64'(SWAP), 64'd1);
        check("t2_segment", 64'(SEGMENT), 64'd1);
        check("t2_loop_cnt", 64'(LOOP_CNT), 64'd0);
        check("t2_pending", 64'(PENDING), 64'd0);
        tick();
        check("t2_swap_one_cycle", 64'(SWAP), 64'd0);

        // 3: SYS_TIME reaching the target, then a target in the past
        SYS_TIME = 57'd990;
        do_update(1'b0, 8'h01, 64'd1000);
        found = 0; swap_at = 57'd0;
        for (int k = 0; k < 30; k++) begin
            cur_t = SYS_TIME;
            tick();
            if (SWAP && !found) begin found = 1; swap_at = cur_t; end
            SYS_TIME = SYS_TIME + 57'd1;
        end
        check("t3_swap_time", 64'(swap_at), 64'd1000);
        SYS_TIME = 57'd990;
        do_update(1'b1, 8'h01, 64'd500);
        check("t3_past_no_swap_yet", 64'(SWAP), 64'd0);
        tick();
        check("t3_past_swap", 64'(SWAP), 64'd1);
        check("t3_past_segment", 64'(SEGMENT), 64'd1);

        // 4: GPIO pin 2 already high at latch; other pin ignored; real edge swaps
        GPIO_IN = 4'b0100;
        tick();
        do_update(1'b0, 8'h02, 64'd2);
        ticks(2);
        GPIO_IN = 4'b0110; tick();
        GPIO_IN = 4'b0100; tick();
        check("t4_no_swap_pending", 64'(PENDING), 64'd1);
        check("t4_no_swap_segment", 64'(SEGMENT), 64'd1);
        GPIO_IN = 4'b0000; ticks(2);
        GPIO_IN = 4'b0100; tick();
        check("t4_edge_swap", 64'(SWAP), 64'd1);
        check("t4_edge_segment", 64'(SEGMENT), 64'd0);
        GPIO_IN = 4'b0000; tick();

        // 5: EXT ping-pong (or a dropped request without the feature)
        REP0 = 16'd0; REP1 = 16'd0;
`ifdef SEGMENT_SWAP_EXT_EN
        do_update(1'b1, 8'hF0, 64'd0);
        pulse_loop();
        check("t5_first_swap", 64'(SEGMENT), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            pulse_loop();
            check("t5_toggle_swap", 64'(SWAP), 64'd1);
            check("t5_toggle_segment", 64'(SEGMENT), 64'(k % 2 == 0 ? 0 : 1));
            check("t5_no_stop", 64'(STOP), 64'd0);
        end
        do_update(1'b0, 8'h00, 64'd0);
        pulse_loop();
`else
        do_update(1'b1, 8'hF0, 64'd0);
        check("t5_dropped_pending", 64'(PENDING), 64'd0);
        ticks(3);
        check("t5_dropped_segment", 64'(SEGMENT), 64'd0);
`endif
        REP0 = 16'd5; REP1 = 16'd5;
        tick();

        // 6: invalid mode cancels a pending request; reset mid-WAIT
        SYS_TIME = 57'd100;
        do_update(1'b1, 8'h01, 64'd5000);
        ticks(2);
        do_update(1'b0, 8'h07, 64'd0);
        check("t6_cancel_pending", 64'(PENDING), 64'd0);
        SYS_TIME = 57'd6000;
        seen_swap = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (SWAP) seen_swap = 1;
        end
        check("t6_no_swap_after_cancel", 64'(seen_swap), 64'd0);
        do_update(1'b1, 8'h01, 64'd7000);
        pulse_loop();
        ticks(2);
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        check("t6_rst_pending", 64'(PENDING), 64'd0);
        check("t6_rst_loop_cnt", 64'(LOOP_CNT), 64'd0);
        SYS_TIME = 57'd8000;
        ticks(3);
        check("t6_rst_no_swap", 64'(SWAP), 64'd0);
        check("t6_rst_segment", 64'(SEGMENT), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST_N           = ($urandom_range(0, 499) != 0);
            UPDATE_SETTINGS = ($urandom_range(0, 7) == 0);
            REQ_RD_SEGMENT  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       TRANSITION_MODE = 8'h00;
                1:       TRANSITION_MODE = 8'h01;
                2:       TRANSITION_MODE = 8'h02;
                3:       TRANSITION_MODE = 8'hF0;
                4:       TRANSITION_MODE = 8'($urandom_range(0, 255));
                default: TRANSITION_MODE = 8'h00;
            endcase
            target = SYS_TIME + 57'($urandom_range(0, 40)) - 57'd10;
            TRANSITION_VALUE = {7'($urandom), target};
            LOOP_END = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) GPIO_IN = 4'($urandom);
            if ($urandom_range(0, 99) == 0) REP0 = pick_rep();
            if ($urandom_range(0, 99) == 0) REP1 = pick_rep();
            tick();
            SYS_TIME = SYS_TIME + 57'($urandom_range(0, 2));
        end
        UPDATE_SETTINGS = 1'b0;
        LOOP_END        = 1'b0;
        RST_N           = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
